// File: rtl/core_loader.sv
// Host-side program loader and execution supervisor for the out-of-order core.
// Stages host words in a FIFO, streams them into the instruction queue, then runs/resumes the core.
module core_loader #(
    parameter int FIFO_DEPTH   = 8,
    parameter int RESUME_DELAY = 4,
    parameter int MAX_EXC      = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        skip_exc,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    input  logic        s_last,
    output logic        instr_wr_en,
    output logic [31:0] wr_instr,
    output logic        core_valid,
    input  logic        exception,
    input  logic [31:0] cmt_pc,
    input  logic        completed,
    output logic        resume,
    output logic [31:0] resume_pc,
    output logic        done,
    output logic        error,
    output logic [15:0] instr_count,
    output logic [7:0]  exc_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = (RESUME_DELAY > 1) ? $clog2(RESUME_DELAY) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        EXC_WAIT,
        RESUME,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [32:0]   fifo_mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic [AW:0]   fifo_count;
    logic          fifo_full, fifo_empty;
    logic [32:0]   head;
    logic          push, pop;
    logic          wr_last;
    logic          start_ok, exc_take, exc_limit;
    logic [31:0]   target;
    logic [DW-1:0] delay_cnt;

    assign fifo_count = wr_ptr - rd_ptr;
    assign fifo_full  = (fifo_count == (AW+1)'(FIFO_DEPTH));
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign head       = fifo_mem[rd_ptr[AW-1:0]];

    assign push      = s_valid & s_ready;
    // Once the last word is popped, hold off so RUN starts the cycle after it is written.
    assign pop       = (state == LOAD) & ~fifo_empty & ~wr_last;
    assign start_ok  = start & ((state == IDLE) | (state == DONE));
    assign exc_take  = (state == RUN) & exception;
    assign exc_limit = ((exc_count + 8'd1) == 8'(MAX_EXC));

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= {s_last, s_data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            instr_wr_en <= 1'b0;
            wr_instr    <= '0;
            wr_last     <= 1'b0;
            instr_count <= '0;
            exc_count   <= '0;
            error       <= 1'b0;
            target      <= '0;
            delay_cnt   <= '0;
        end else begin
            state       <= state_nxt;
            instr_wr_en <= pop;
            wr_last     <= pop & head[32];
            if (pop) begin
                wr_instr <= head[31:0];
            end
            if (start_ok) begin
                instr_count <= '0;
                exc_count   <= '0;
                error       <= 1'b0;
            end else begin
                if (pop && instr_count != 16'hFFFF) begin
                    instr_count <= instr_count + 16'd1;
                end
                if (exc_take) begin
                    exc_count <= exc_count + 8'd1;
                    if (exc_limit) error <= 1'b1;
                end
            end
            if (exc_take) begin
                target    <= cmt_pc + (skip_exc ? 32'd4 : 32'd0);
                delay_cnt <= DW'(RESUME_DELAY - 1);
            end else if (state == EXC_WAIT && delay_cnt != '0) begin
                delay_cnt <= delay_cnt - 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        s_ready    = 1'b0;
        core_valid = 1'b0;
        resume     = 1'b0;
        resume_pc  = '0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                s_ready = ~rst & ~fifo_full;
                if (start) state_nxt = LOAD;
            end
            LOAD: begin
                s_ready = ~rst & ~fifo_full;
                if (wr_last) state_nxt = RUN;
            end
            RUN: begin
                core_valid = 1'b1;
                if (exception) begin
                    state_nxt = exc_limit ? DONE : EXC_WAIT;
                end else if (completed) begin
                    state_nxt = DONE;
                end
            end
            EXC_WAIT: begin
                if (delay_cnt == '0) state_nxt = RESUME;
            end
            RESUME: begin
                resume    = 1'b1;
                resume_pc = target;
                state_nxt = RUN;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_nxt = LOAD;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
